// File: rtl/fetch_queue.sv
// First-word-fall-through {PC, instruction} queue between fetch and decode.
// Head entry is read combinationally; a flush discards every entry in one cycle.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int         PTR_W     = $clog2(DEPTH),
  localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               push, pop, wr_en;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? mem_q[rd_ptr_q].pc    : 32'h0;
  assign out_instr = out_valid ? mem_q[rd_ptr_q].instr : NOP_INSTR;
  assign count     = count_q;

  assign push  = in_valid  & in_ready;
  assign pop   = out_valid & out_ready;
  // Flush drops the offered entry, so storage is not written that cycle either.
  assign wr_en = push & ~flush & ~reset;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_pc, in_instr, out_pc, out_instr;
  logic [CNT_W-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0][63:32] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (mq.size() != 0) ? mq[0][31:0] : NOP;
  endfunction

  // Advance one clock; the model applies the queue rules to the pre-edge inputs.
  task automatic tick();
    bit m_push, m_pop;
    m_push = in_valid && (mq.size() != DEPTH);
    m_pop  = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (reset || flush) mq.delete();
    else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = '0; in_instr = '0;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1; in_pc = pc; in_instr = $urandom;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    vectors++;
    if (count !== 0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++;
    if (out_valid !== 0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_instr !== NOP) begin miscompares++; $display("FAIL reset_out_instr got %h want %h", out_instr, NOP); end
    vectors++;
    if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'(i * 4));
      tick();
      vectors++;
      if (count !== CNT_W'(i + 1)) begin miscompares++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
      vectors++;
      if (out_pc !== 32'h0 || out_instr !== exp_instr()) begin
        miscompares++; $display("FAIL fill_head got %h/%h want 0/%h", out_pc, out_instr, exp_instr());
      end
    end
    vectors++;
    if (in_ready !== 0) begin miscompares++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    offer(32'h10);
    tick();
    in_valid = 0;
    vectors++;
    if (count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL full_refuse_count got %0d want %0d", count, DEPTH); end
    vectors++;
    if (out_pc !== 32'h0) begin miscompares++; $display("FAIL full_refuse_head got %h want 0", out_pc); end
  endtask

  task automatic test_drain();
    idle();
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (out_valid !== 1 || out_pc !== 32'(i * 4) || out_instr !== exp_instr()) begin
        miscompares++;
        $display("FAIL drain_order got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 out_valid, out_pc, out_instr, i * 4, exp_instr());
      end
      tick();
    end
    out_ready = 0;
    vectors++;
    if (out_valid !== 0 || count !== 0) begin
      miscompares++; $display("FAIL drain_empty got v=%b count=%0d want v=0 count=0", out_valid, count);
    end
    vectors++;
    if (out_instr !== NOP || out_pc !== 0) begin
      miscompares++; $display("FAIL drain_nop got %h/%h want 0/%h", out_pc, out_instr, NOP);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    idle();
    pc = 32'h100;
    for (int i = 0; i < 2; i++) begin offer(pc); tick(); pc += 4; end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      offer(pc);
      pc += 4;
      vectors++;
      if (out_pc !== exp_pc() || out_instr !== exp_instr()) begin
        miscompares++; $display("FAIL b2b_head got %h/%h want %h/%h", out_pc, out_instr, exp_pc(), exp_instr());
      end
      tick();
      vectors++;
      if (count !== 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", count); end
    end
    vectors++;
    if (out_pc !== 32'h128) begin miscompares++; $display("FAIL b2b_final_pc got %h want 128", out_pc); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin offer(32'h200 + 32'(i * 4)); tick(); end
    offer(32'hDEAD_0000);
    flush = 1;
    out_ready = 1;
    tick();
    idle();
    vectors++;
    if (count !== 0 || out_valid !== 0) begin
      miscompares++; $display("FAIL flush_empty got count=%0d v=%b want 0/0", count, out_valid);
    end
    vectors++;
    if (in_ready !== 1 || out_instr !== NOP) begin
      miscompares++; $display("FAIL flush_outputs got rdy=%b instr=%h want 1/%h", in_ready, out_instr, NOP);
    end
    offer(32'h300);
    tick();
    idle();
    vectors++;
    if (count !== 1 || out_pc !== 32'h300 || out_instr !== exp_instr()) begin
      miscompares++; $display("FAIL flush_resume got count=%0d pc=%h want 1/300", count, out_pc);
    end
    out_ready = 1;
    tick();
    idle();
    vectors++;
    if (out_valid !== 0) begin miscompares++; $display("FAIL flush_leftover got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_full();
    idle();
    for (int i = 0; i < DEPTH; i++) begin offer(32'h400 + 32'(i * 4)); tick(); end
    // full: a simultaneous pop must not let the offered entry in
    offer(32'h4F0);
    out_ready = 1;
    tick();
    idle();
    vectors++;
    if (count !== CNT_W'(DEPTH - 1) || out_pc !== 32'h404) begin
      miscompares++; $display("FAIL full_pushpop got count=%0d pc=%h want %0d/404", count, out_pc, DEPTH - 1);
    end
    offer(32'h410);
    tick();
    vectors++;
    if (count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL refill_count got %0d want %0d", count, DEPTH); end
    reset = 1;
    out_ready = 1;
    tick();
    reset = 0;
    in_valid = 0;
    vectors++;
    if (count !== 0 || in_ready !== 1 || out_valid !== 0) begin
      miscompares++; $display("FAIL reset_full got count=%0d rdy=%b v=%b want 0/1/0", count, in_ready, out_valid);
    end
    tick();
    vectors++;
    if (count !== 0 || out_valid !== 0) begin
      miscompares++; $display("FAIL reset_full_after got count=%0d v=%b want 0/0", count, out_valid);
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    idle();
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      in_pc     = pc;
      in_instr  = $urandom;
      if (in_valid && in_ready) pc += 4;
      vectors++;
      if (count !== CNT_W'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() != DEPTH) || out_pc !== exp_pc() || out_instr !== exp_instr()) begin
        miscompares++;
        $display("FAIL random_cycle%0d got c=%0d v=%b r=%b pc=%h in=%h want c=%0d pc=%h in=%h",
                 i, count, out_valid, in_ready, out_pc, out_instr, mq.size(), exp_pc(), exp_instr());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
